// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with write-back bypass, debug read port and a
// per-register pending-writer scoreboard that produces the ID-stage stall.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_RD-1:0]          rd_used,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       issue_valid,
    input  logic                       issue_wb_en,
    input  logic [ADDR_W-1:0]          issue_dest,
    output logic                       stall,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_dest,
    input  logic [DATA_W-1:0]          wb_value,
    input  logic [ADDR_W-1:0]          dbg_addr,
    output logic [DATA_W-1:0]          dbg_data,
    output logic [NUM_REGS-1:0]        pending_vec,
    output logic                       err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic [CNT_W-1:0]    cnt_r  [NUM_REGS];
    logic                err_underflow_r;

    logic [NUM_REGS-1:0] wb_hit_s;
    logic [NUM_REGS-1:0] iss_hit_s;
    logic [NUM_REGS-1:0] busy_s;
    logic [NUM_REGS-1:0] dec_s;
    logic [NUM_REGS-1:0] busy_after_s;
    logic [NUM_REGS-1:0] inc_s;
    logic [NUM_RD-1:0]   hazard_s;
    logic                sat_s;
    logic                stall_s;
    logic                accept_s;
    logic                underflow_s;

    // Per-register decode of write-back and issue, plus the post-write-back busy view
    always_comb begin
        wb_hit_s     = {NUM_REGS{1'b0}};
        iss_hit_s    = {NUM_REGS{1'b0}};
        busy_s       = {NUM_REGS{1'b0}};
        dec_s        = {NUM_REGS{1'b0}};
        busy_after_s = {NUM_REGS{1'b0}};
        sat_s        = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wb_hit_s[r]     = wb_en && (wb_dest == ADDR_W'(r));
            iss_hit_s[r]    = issue_wb_en && (issue_dest == ADDR_W'(r));
            busy_s[r]       = (cnt_r[r] != CNT_ZERO);
            dec_s[r]        = wb_hit_s[r] && busy_s[r];
            // A write-back retiring the last writer clears the hazard this cycle
            busy_after_s[r] = ((cnt_r[r] - CNT_W'(dec_s[r])) != CNT_ZERO);
            sat_s           = sat_s | (iss_hit_s[r] & (cnt_r[r] == CNT_MAX) & ~dec_s[r]);
        end
    end

    // Read ports: register file lookup, source hazard, then write-back bypass
    always_comb begin
        rd_data  = {(NUM_RD*DATA_W){1'b0}};
        hazard_s = {NUM_RD{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rd_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    rd_data[k*DATA_W +: DATA_W] = regs_r[r];
                    hazard_s[k]                 = rd_used[k] & busy_after_s[r];
                end else begin
                    hazard_s[k] = hazard_s[k];
                end
            end
            if (wb_en && (rd_addr[k*ADDR_W +: ADDR_W] == wb_dest)) begin
                rd_data[k*DATA_W +: DATA_W] = wb_value;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = rd_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Debug read straight from the array, never bypassed
    always_comb begin
        dbg_data = {DATA_W{1'b0}};
        for (int r = 0; r < NUM_REGS; r++) begin
            if (dbg_addr == ADDR_W'(r)) begin
                dbg_data = regs_r[r];
            end else begin
                dbg_data = dbg_data;
            end
        end
    end

    assign stall_s     = issue_valid & ((|hazard_s) | sat_s);
    assign accept_s    = issue_valid & ~stall_s;
    assign inc_s       = {NUM_REGS{accept_s}} & iss_hit_s;
    assign underflow_s = |(wb_hit_s & ~busy_s);

    // Register array, pending counters and sticky underflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_r[r] <= {DATA_W{1'b0}};
                cnt_r[r]  <= CNT_ZERO;
            end
            err_underflow_r <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wb_hit_s[r]) begin
                    regs_r[r] <= wb_value;
                end else begin
                    regs_r[r] <= regs_r[r];
                end
                cnt_r[r] <= cnt_r[r] + CNT_W'(inc_s[r]) - CNT_W'(dec_s[r]);
            end
            err_underflow_r <= err_underflow_r | underflow_s;
        end
    end

    assign stall         = stall_s;
    assign pending_vec   = busy_s;
    assign err_underflow = err_underflow_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_regfile_scoreboard;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_RD   = 2;
    localparam int CNT_W    = 2;

    localparam int S_RD0   = 0;
    localparam int S_RD1   = 1;
    localparam int S_STALL = 2;
    localparam int S_PEND  = 3;
    localparam int S_DBG   = 4;
    localparam int S_ERR   = 5;

    logic                      clk;
    logic                      rst;
    logic [NUM_RD*ADDR_W-1:0]  rd_addr;
    logic [NUM_RD-1:0]         rd_used;
    logic [NUM_RD*DATA_W-1:0]  rd_data;
    logic                      issue_valid;
    logic                      issue_wb_en;
    logic [ADDR_W-1:0]         issue_dest;
    logic                      stall;
    logic                      wb_en;
    logic [ADDR_W-1:0]         wb_dest;
    logic [DATA_W-1:0]         wb_value;
    logic [ADDR_W-1:0]         dbg_addr;
    logic [DATA_W-1:0]         dbg_data;
    logic [NUM_REGS-1:0]       pending_vec;
    logic                      err_underflow;

    regfile_scoreboard #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
        .stall(stall),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .pending_vec(pending_vec), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic push_exp(input string name, input int sel, input logic [31:0] v);
        chk_t c;
        c.sel = sel;
        c.exp = v;
        exp_q.push_back(c);
        name_q.push_back(name);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RD0:   return rd_data[31:0];
            S_RD1:   return rd_data[63:32];
            S_STALL: return {31'd0, stall};
            S_PEND:  return {16'd0, pending_vec};
            S_DBG:   return dbg_data;
            S_ERR:   return {31'd0, err_underflow};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        chk_t        c;
        string       n;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            c   = exp_q.pop_front();
            n   = name_q.pop_front();
            act = observe(c.sel);
            n_cmp++;
            if (act !== c.exp) begin
                n_bad++;
                $display("FAIL %s: got %h, expected %h", n, act, c.exp);
            end
        end
    end

    task automatic idle();
        rd_addr     = '0;
        rd_used     = '0;
        issue_valid = 1'b0;
        issue_wb_en = 1'b0;
        issue_dest  = '0;
        wb_en       = 1'b0;
        wb_dest     = '0;
        wb_value    = '0;
        dbg_addr    = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] dest);
        issue_valid = 1'b1;
        issue_wb_en = 1'b1;
        issue_dest  = dest;
    endtask

    task automatic wb(input logic [3:0] dest, input logic [31:0] v);
        wb_en    = 1'b1;
        wb_dest  = dest;
        wb_value = v;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;

        // reset state
        idle(); issue_valid = 1'b1;
        push_exp("rst_pend", S_PEND, 32'h0);
        push_exp("rst_stall", S_STALL, 32'h0);
        push_exp("rst_err", S_ERR, 32'h0);
        push_exp("rst_rd0", S_RD0, 32'h0);
        step();

        // write R3 without a pending writer, bypass seen on read port
        idle(); wb(4'd3, 32'h55); rd_addr[3:0] = 4'd3;
        push_exp("bypass_r3", S_RD0, 32'h55);
        step();
        idle(); dbg_addr = 4'd3;
        push_exp("dbg_r3", S_DBG, 32'h55);
        push_exp("pend_after_wb", S_PEND, 32'h0);
        push_exp("underflow_set", S_ERR, 32'h1);
        step();
        // debug port is not bypassed, read port is
        idle(); wb(4'd3, 32'h77); dbg_addr = 4'd3; rd_addr[3:0] = 4'd3;
        push_exp("dbg_no_bypass", S_DBG, 32'h55);
        push_exp("rd_bypass_77", S_RD0, 32'h77);
        step();

        rst = 1'b1; idle(); step(); rst = 1'b0;

        // issue to R2, then source hazards
        idle(); dbg_addr = 4'd3; issue(4'd2);
        push_exp("rst2_dbg", S_DBG, 32'h0);
        push_exp("rst2_err", S_ERR, 32'h0);
        push_exp("issue_r2", S_STALL, 32'h0);
        step();
        idle(); issue_valid = 1'b1; rd_addr[3:0] = 4'd2; rd_used = 2'b01;
        push_exp("raw_port0", S_STALL, 32'h1);
        push_exp("pend_r2", S_PEND, 32'h4);
        step();
        idle(); issue_valid = 1'b1; rd_addr[7:4] = 4'd2; rd_used = 2'b10;
        push_exp("raw_port1", S_STALL, 32'h1);
        step();
        idle(); issue_valid = 1'b1; rd_addr[3:0] = 4'd2; rd_used = 2'b00;
        push_exp("unused_src", S_STALL, 32'h0);
        step();
        idle(); issue_valid = 1'b1; rd_addr[3:0] = 4'd2; rd_used = 2'b01; wb(4'd2, 32'hDEAD);
        push_exp("wb_clears_stall", S_STALL, 32'h0);
        push_exp("wb_bypass_dead", S_RD0, 32'hDEAD);
        step();
        idle(); dbg_addr = 4'd2;
        push_exp("pend_r2_clear", S_PEND, 32'h0);
        push_exp("no_underflow", S_ERR, 32'h0);
        push_exp("dbg_r2", S_DBG, 32'hDEAD);
        step();

        // saturate R5 at three writers
        for (int i = 0; i < 3; i++) begin
            idle(); issue(4'd5);
            push_exp("issue_r5", S_STALL, 32'h0);
            step();
        end
        idle(); issue(4'd5);
        push_exp("sat_stall", S_STALL, 32'h1);
        push_exp("pend_r5", S_PEND, 32'h20);
        step();
        idle(); issue(4'd5);
        push_exp("sat_stall_hold", S_STALL, 32'h1);
        step();
        idle(); issue(4'd5); wb(4'd5, 32'h11);
        push_exp("sat_with_wb", S_STALL, 32'h0);
        step();
        idle(); issue(4'd5);
        push_exp("sat_still_3", S_STALL, 32'h1);
        step();
        idle(); wb(4'd5, 32'h12);
        step();
        idle(); issue_valid = 1'b1; rd_addr[3:0] = 4'd5; rd_used = 2'b01; wb(4'd5, 32'h13);
        push_exp("raw_cnt2_wb", S_STALL, 32'h1);
        push_exp("rd_bypass_13", S_RD0, 32'h13);
        step();
        idle(); issue_valid = 1'b1; rd_addr[3:0] = 4'd5; rd_used = 2'b01; wb(4'd5, 32'h14);
        push_exp("pend_r5_last", S_PEND, 32'h20);
        push_exp("raw_cnt1_wb", S_STALL, 32'h0);
        step();
        idle(); dbg_addr = 4'd5;
        push_exp("pend_r5_drained", S_PEND, 32'h0);
        push_exp("r5_no_underflow", S_ERR, 32'h0);
        push_exp("dbg_r5", S_DBG, 32'h14);
        step();

        // read-own-destination, then simultaneous issue and write-back
        idle(); issue(4'd1); rd_addr[3:0] = 4'd1; rd_used = 2'b01;
        push_exp("self_src_dest", S_STALL, 32'h0);
        step();
        idle(); issue(4'd1); wb(4'd1, 32'h1);
        push_exp("inc_dec_issue", S_STALL, 32'h0);
        step();
        idle(); wb(4'd1, 32'h2);
        push_exp("pend_r1_kept", S_PEND, 32'h2);
        step();
        idle(); issue(4'd4);
        push_exp("pend_r1_clear", S_PEND, 32'h0);
        push_exp("r1_no_underflow", S_ERR, 32'h0);
        step();
        idle(); issue(4'd4);
        push_exp("pend_r4", S_PEND, 32'h10);
        step();

        // reset wins over write-back and issue
        rst = 1'b1; idle(); issue(4'd4); wb(4'd4, 32'h99);
        step();
        rst = 1'b0;
        idle(); issue_valid = 1'b1; rd_addr = {4'd4, 4'd2}; rd_used = 2'b11; dbg_addr = 4'd5;
        push_exp("rst3_stall", S_STALL, 32'h0);
        push_exp("rst3_rd_r2", S_RD0, 32'h0);
        push_exp("rst3_rd_r4", S_RD1, 32'h0);
        push_exp("rst3_pend", S_PEND, 32'h0);
        push_exp("rst3_err", S_ERR, 32'h0);
        push_exp("rst3_dbg_r5", S_DBG, 32'h0);
        step();
        idle();

        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d checks left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
